stream_fifo: RTL

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo_if.sv | 24 ++
 rtl/stream_fifo.sv | 88 ++++++++
 2 files changed

// File: rtl/stream_fifo_if.sv
// Stream FIFO handshake bundle: upstream write side, downstream read side and status flags.
// A word transfers on any rising edge where its valid and ready are both 1; valid never waits on ready.
interface stream_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_in;
  logic                  full_out;
  logic                  empty_out;

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, full_out, empty_out
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, full_out, empty_out
  );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO of DEPTH words (any DEPTH >= 2).
// Define STREAM_FIFO_LEVEL_EN to add the level_out occupancy port.
module stream_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  stream_fifo_if.slave               bus
`ifdef STREAM_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level_out
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic full, empty, ready, valid, push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    // ready depends only on stored occupancy and reset, never on ready_in.
    ready = !rst_in && !full;
    valid = !empty;
    push  = bus.valid_in && ready;
    pop   = valid && bus.ready_in;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (push) begin
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      mem_d[wr_ptr_q] = bus.data_in;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left uncleared by reset; count=0 already hides stale words.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign bus.ready_out = ready;
  assign bus.valid_out = valid;
  assign bus.full_out  = full;
  assign bus.empty_out = empty;
  assign bus.data_out  = valid ? mem_q[rd_ptr_q] : '0;

`ifdef STREAM_FIFO_LEVEL_EN
  assign level_out = count_q;
`endif

endmodule
